fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 16-bit pipelined RISC core.
- Tracks destination-register state of in-flight instructions through the EX, MEM and WB stages.
- Drives the 2-bit select of both ALU operand-forwarding muxes: 0 = register file, 1 = MEM-stage forward, 2 = WB-stage forward.
- Detects load-use hazards, stalls decode for one cycle and inserts an EX bubble.

Parameters:
- REG_AW, 3, register-address width (8 GPRs).
- R0_ZERO, 1, when 1, register 0 is hardwired zero, is never forwarded and never causes a hazard.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  REG_AW  source register 1 of decode instruction.
- id_rs2  in  REG_AW  source register 2 of decode instruction.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination register.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a memory load.
- flush  in  1  branch taken in EX; discard decode instruction.
- stall  out  1  hold PC and IF/ID register this cycle (combinational).
- fwd_sel1  out  2  registered select for ALU operand-1 mux, valid during EX.
- fwd_sel2  out  2  registered select for ALU operand-2 mux, valid during EX.
- ex_valid  out  1  EX stage holds a real instruction (not a bubble).
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Internal stage records:
  - EX: valid, rd, we, load.
  - MEM: valid, rd, we, load.
  - WB: valid, rd, we.
- Reset (async, rst=1): all valid bits 0, all rd 0, fwd_sel1/2 = 0, stall_cycles = 0; stall evaluates to 0 because no stage is valid.
- Every clock edge:
  - MEM <= EX.
  - WB <= MEM.
  - No downstream back-pressure.
- Data sources:
  - mem_forward carries the ALU result of the MEM-stage instruction only; load data is never forwarded from MEM.
  - wb_forward carries the final writeback value, including load data.
  - The register file is write-through; a WB write in the same cycle as an ID read needs no forwarding from this block.
- Match definitions, for source s in {rs1, rs2}:
  - hitX(s) = id_rsX_used & X.valid & X.we & (X.rd == s) & !(R0_ZERO & s == 0), for stage X in {EX, MEM}.
- Select computation at decode, registered into EX:
  - sel = 1 if hitEX(s) & !EX.load.
  - else sel = 2 if hitMEM(s).
  - else sel = 0.
  - The younger producer (EX) has priority over MEM.
- Load-use hazard: stall = id_valid & !flush & ((hitEX(rs1) & EX.load) | (hitEX(rs2) & EX.load)).
  - Exactly one stall cycle per hazard. After the stall the load sits in MEM, so the held instruction recomputes to sel = 2.
- EX capture on a clock edge:
  - If flush or stall or !id_valid: EX.valid <= 0, EX.we <= 0, fwd_sel1/2 <= 0 (bubble).
  - Otherwise: EX <= {1, id_rd, id_we, id_is_load}, fwd_selX <= computed sel.
- flush has priority over stall. The flushed decode instruction never enters EX; the instruction currently in EX continues normally.
- stall_cycles increments on each edge where stall = 1 and holds at all-ones.
- Operand independence: rs1 and rs2 are evaluated separately; both may select different sources in the same cycle.
- Reset asserted mid-stall: pipeline records clear immediately; stall drops in the same cycle.

Test Plan:
- Back-to-back dependency: ADD r3 then SUB r4,r3,r2 → during SUB in EX, fwd_sel1 = 1, fwd_sel2 = 0, stall never asserted.
- Two-apart dependency: ADD r5; NOP; AND r6,r1,r5 → fwd_sel2 = 2 in AND's EX cycle; with an intervening ADD r5 instead of NOP → fwd_sel2 = 1 (EX priority).
- Load-use: LD r2; ADD r7,r2,r2 → stall = 1 for exactly one cycle, ex_valid = 0 the next cycle, then ADD enters EX with fwd_sel1 = fwd_sel2 = 2; stall_cycles = 1.
- R0 and unused sources: ADD r0 then SUB r1,r0,r0 → selects 0; LD r0 followed by a reader of r0 → no stall; a matching rs2 with id_rs2_used = 0 → select 0, no stall.
- Flush during hazard: LD r2 in EX, dependent ADD in decode with flush = 1 → stall = 0, next cycle ex_valid = 0, counter unchanged.
- Reset mid-stream: assert rst while stall = 1 → stall, ex_valid, fwd_sel1/2 and stall_cycles read 0 immediately; counter saturation checked by forcing CNT_W = 4 with 20 hazards → reads 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use hazard control for the 16-bit pipelined core.
// Tracks destination registers of the EX/MEM/WB instructions and registers ALU mux selects into EX.
module fwd_hazard_ctrl #(
    parameter int REG_AW  = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // EX stage record
    logic              vld_p0;
    logic [REG_AW-1:0] rd_p0;
    logic              we_p0;
    logic              load_p0;

    // MEM stage record
    logic              vld_p1;
    logic [REG_AW-1:0] rd_p1;
    logic              we_p1;
    logic              load_p1;

    // WB stage record
    logic              vld_p2;
    logic [REG_AW-1:0] rd_p2;
    logic              we_p2;

    logic       hit_ex1, hit_ex2, hit_mem1, hit_mem2;
    logic       load_hit;
    logic       capture;
    logic [1:0] sel1_next, sel2_next;

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] r);
        return (R0_ZERO != 0) && (r == '0);
    endfunction

    function automatic logic src_hit(input logic used, input logic vld, input logic we,
                                     input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return used && vld && we && (rd == rs) && !is_zero_reg(rs);
    endfunction

    // EX producer is younger, so it wins; a load in EX cannot forward and is handled by the stall.
    function automatic logic [1:0] pick_sel(input logic hit_ex, input logic ex_load, input logic hit_mem);
        if (hit_ex && !ex_load) return SEL_MEM;
        if (hit_mem)            return SEL_WB;
        return SEL_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        hit_ex1   = src_hit(id_rs1_used, vld_p0, we_p0, rd_p0, id_rs1);
        hit_ex2   = src_hit(id_rs2_used, vld_p0, we_p0, rd_p0, id_rs2);
        hit_mem1  = src_hit(id_rs1_used, vld_p1, we_p1, rd_p1, id_rs1);
        hit_mem2  = src_hit(id_rs2_used, vld_p1, we_p1, rd_p1, id_rs2);
        load_hit  = (hit_ex1 || hit_ex2) && load_p0;
        stall     = id_valid && !flush && load_hit;
        capture   = id_valid && !flush && !load_hit;
        sel1_next = pick_sel(hit_ex1, load_p0, hit_mem1);
        sel2_next = pick_sel(hit_ex2, load_p0, hit_mem2);
    end

    // Decode -> EX capture; bubbles carry no write so they never match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            rd_p0    <= '0;
            we_p0    <= 1'b0;
            load_p0  <= 1'b0;
            fwd_sel1 <= SEL_RF;
            fwd_sel2 <= SEL_RF;
        end else if (capture) begin
            vld_p0   <= 1'b1;
            rd_p0    <= id_rd;
            we_p0    <= id_we;
            load_p0  <= id_is_load;
            fwd_sel1 <= sel1_next;
            fwd_sel2 <= sel2_next;
        end else begin
            vld_p0   <= 1'b0;
            we_p0    <= 1'b0;
            load_p0  <= 1'b0;
            fwd_sel1 <= SEL_RF;
            fwd_sel2 <= SEL_RF;
        end
    end

    // EX -> MEM -> WB, never back-pressured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            we_p1   <= 1'b0;
            load_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            rd_p2   <= '0;
            we_p2   <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            rd_p1   <= rd_p0;
            we_p1   <= we_p0;
            load_p1 <= load_p0;
            vld_p2  <= vld_p1;
            rd_p2   <= rd_p1;
            we_p2   <= we_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end

    assign ex_valid = vld_p0;

    // WB writes go through the register file, so the WB record and MEM load flag need no select logic.
    logic unused_wb;
    assign unused_wb = ^{vld_p2, rd_p2, we_p2, load_p1};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: table of decode vectors with hand-derived expectations, scoreboard
// queue for the registered EX outputs, plus reset-mid-stall and counter saturation sequences.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
    logic [2:0] id_rs1, id_rs2, id_rd;

    logic        stall, ex_valid;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [15:0] stall_cycles;

    logic        stall4, ex_valid4;
    logic [1:0]  fwd_sel1_4, fwd_sel2_4;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .ex_valid(ex_valid), .stall_cycles(stall_cycles)
    );

    fwd_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall4), .fwd_sel1(fwd_sel1_4),
        .fwd_sel2(fwd_sel2_4), .ex_valid(ex_valid4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        logic       v, u1, u2, we, ld, fl;
        logic [2:0] rs1, rs2, rd;
        int         st, exv, s1, s2;
    } vec_t;

    typedef struct {
        int exv, s1, s2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cnt16 = 0;
    int   cnt4 = 0;

    function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2, int rd, int we, int ld,
                                int fl, int st, int exv, int s1, int s2);
        vec_t r;
        r.v = v[0]; r.rs1 = rs1[2:0]; r.rs2 = rs2[2:0]; r.u1 = u1[0]; r.u2 = u2[0];
        r.rd = rd[2:0]; r.we = we[0]; r.ld = ld[0]; r.fl = fl[0];
        r.st = st; r.exv = exv; r.s1 = s1; r.s2 = s2;
        return r;
    endfunction

    function automatic vec_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.v; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
        id_rd = v.rd; id_we = v.we; id_is_load = v.ld; flush = v.fl;
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk("stall", int'(stall), v.st);
        e.exv = v.exv; e.s1 = v.s1; e.s2 = v.s2;
        sb.push_back(e);
        @(posedge clk);
        if (v.st != 0) begin
            cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("ex_valid", int'(ex_valid), e.exv);
            chk("fwd_sel1", int'(fwd_sel1), e.s1);
            chk("fwd_sel2", int'(fwd_sel2), e.s2);
            chk("stall_cycles", int'(stall_cycles), cnt16);
            chk("stall_cycles_w4", int'(stall_cycles4), cnt4);
        end
    endtask

    initial begin
        // back-to-back: ADD r3 ; SUB r4,r3,r2
        vecs.push_back(mk(1,1,1,1,1,3,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,3,2,1,1,4,1,0,0, 0,1,1,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        // two apart with NOP, then with intervening ADD r5
        vecs.push_back(mk(1,1,1,1,1,5,1,0,0, 0,1,0,0));
        vecs.push_back(nop());
        vecs.push_back(mk(1,1,5,1,1,6,1,0,0, 0,1,0,2));
        vecs.push_back(nop()); vecs.push_back(nop());
        vecs.push_back(mk(1,1,1,1,1,5,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,1,1,1,5,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,5,1,1,6,1,0,0, 0,1,0,1));
        vecs.push_back(nop()); vecs.push_back(nop());
        // load-use: LD r2 ; ADD r7,r2,r2 (stall, then re-presented)
        vecs.push_back(mk(1,1,0,1,0,2,1,1,0, 0,1,0,0));
        vecs.push_back(mk(1,2,2,1,1,7,1,0,0, 1,0,0,0));
        vecs.push_back(mk(1,2,2,1,1,7,1,0,0, 0,1,2,2));
        vecs.push_back(nop()); vecs.push_back(nop());
        // r0 never forwarded, never hazards
        vecs.push_back(mk(1,1,1,1,1,0,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,1,1,1,1,0,0, 0,1,0,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        vecs.push_back(mk(1,1,0,1,0,0,1,1,0, 0,1,0,0));
        vecs.push_back(mk(1,0,0,1,1,3,1,0,0, 0,1,0,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        // matching rs2 that is not read
        vecs.push_back(mk(1,1,0,1,0,4,1,1,0, 0,1,0,0));
        vecs.push_back(mk(1,1,4,1,0,5,1,0,0, 0,1,0,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        // independent operands: rs1 from EX producer, rs2 from MEM producer
        vecs.push_back(mk(1,1,1,1,1,3,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,1,1,1,4,1,0,0, 0,1,0,0));
        vecs.push_back(mk(1,4,3,1,1,5,1,0,0, 0,1,1,2));
        vecs.push_back(nop()); vecs.push_back(nop());
        // flush beats the load-use stall
        vecs.push_back(mk(1,1,0,1,0,2,1,1,0, 0,1,0,0));
        vecs.push_back(mk(1,2,2,1,1,7,1,0,1, 0,0,0,0));
        vecs.push_back(mk(1,3,3,1,1,1,1,0,0, 0,1,0,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        // invalid decode slot never stalls
        vecs.push_back(mk(1,1,0,1,0,2,1,1,0, 0,1,0,0));
        vecs.push_back(mk(0,2,2,1,1,7,1,0,0, 0,0,0,0));
        vecs.push_back(nop()); vecs.push_back(nop());
        // load two ahead comes from WB, no stall
        vecs.push_back(mk(1,1,0,1,0,2,1,1,0, 0,1,0,0));
        vecs.push_back(nop());
        vecs.push_back(mk(1,2,0,1,0,7,1,0,0, 0,1,2,0));
        vecs.push_back(nop()); vecs.push_back(nop());

        rst = 1'b1;
        drive(mk(1,2,2,1,1,7,1,0,0, 0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", int'(stall), 0);
        chk("reset_ex_valid", int'(ex_valid), 0);
        chk("reset_fwd_sel1", int'(fwd_sel1), 0);
        chk("reset_fwd_sel2", int'(fwd_sel2), 0);
        chk("reset_stall_cycles", int'(stall_cycles), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(nop());

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // reset while a load-use stall is being raised
        step(mk(1,3,3,1,1,1,1,0,0, 0,1,0,0));
        step(mk(1,1,0,1,0,2,1,1,0, 0,1,1,0));
        @(negedge clk);
        drive(mk(1,2,2,1,1,7,1,0,0, 0,0,0,0));
        #1;
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_ex_valid", int'(ex_valid), 1);
        chk("pre_rst_fwd_sel1", int'(fwd_sel1), 1);
        chk("pre_rst_stall_cycles", int'(stall_cycles), cnt16);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_ex_valid", int'(ex_valid), 0);
        chk("mid_rst_fwd_sel1", int'(fwd_sel1), 0);
        chk("mid_rst_fwd_sel2", int'(fwd_sel2), 0);
        chk("mid_rst_stall_cycles", int'(stall_cycles), 0);
        chk("mid_rst_stall_cycles_w4", int'(stall_cycles4), 0);
        cnt16 = 0;
        cnt4 = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(nop());

        // 20 load-use hazards: narrow counter must pin at all-ones
        for (int h = 0; h < 20; h++) begin
            step(mk(1,1,0,0,0,2,1,1,0, 0,1,0,0));
            step(mk(1,2,2,1,1,7,1,0,0, 1,0,0,0));
            step(mk(1,2,2,1,1,7,1,0,0, 0,1,2,2));
        end
        chk("sat_w4_final", int'(stall_cycles4), 15);
        chk("cnt_w16_final", int'(stall_cycles), 20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
